// File: rtl/video_axi_pkg.sv
// Shared types and AXI constants for the video memory arbiter.
`ifndef ROCKET_MEM_DAT_WIDTH
`define ROCKET_MEM_DAT_WIDTH 64
`endif

package video_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR_DATA,
        ST_WR_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/arb2_rr.sv
// Two-way round-robin arbiter; override forces the read side on a tie.
module arb2_rr
    import video_axi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_rd,
    input  logic req_wr,
    input  logic urgent,
    input  logic update,
    output logic gnt_rd,
    output logic gnt_wr
);

    req_id_t last_srv;

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (req_rd && req_wr) begin
            if (urgent || (last_srv == REQ_WR)) gnt_rd = 1'b1;
            else                                gnt_wr = 1'b1;
        end else if (req_rd) begin
            gnt_rd = 1'b1;
        end else if (req_wr) begin
            gnt_wr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                     last_srv <= REQ_WR;
        else if (update && gnt_rd)   last_srv <= REQ_RD;
        else if (update && gnt_wr)   last_srv <= REQ_WR;
    end

endmodule

// File: rtl/video_axi_arbiter.sv
// Shares one AXI4 master between display-fetch burst reads and single-beat host writes.
//
//  state           | meaning
//  ST_IDLE         | no transaction; arbitrate rd_req/wr_req
//  ST_RD_ADDR      | ARVALID up, waiting for ARREADY
//  ST_RD_DATA      | RREADY up, counting read beats
//  ST_WR_ADDR_DATA | AWVALID/WVALID up, each dropped on its own handshake
//  ST_WR_RESP      | BREADY up, waiting for BVALID
module video_axi_arbiter
    import video_axi_pkg::*;
#(
    parameter int DATA_WIDTH    = `ROCKET_MEM_DAT_WIDTH,
    parameter int VIDEOMEM_SIZE = 18,
    parameter int BURST_LEN     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [VIDEOMEM_SIZE-1:0] rd_addr,
    input  logic                     rd_urgent,
    output logic                     rd_ack,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     rd_done,
    output logic                     rd_err,
    input  logic                     wr_req,
    input  logic [VIDEOMEM_SIZE-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ack,
    output logic                     wr_done,
    output logic                     wr_err,
    output logic [VIDEOMEM_SIZE-1:0] AWADDR,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [DATA_WIDTH-1:0]    WDATA,
    output logic                     WLAST,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    output logic                     BREADY,
    output logic [VIDEOMEM_SIZE-1:0] ARADDR,
    output logic [7:0]               ARLEN,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_WIDTH-1:0]    RDATA,
    input  logic [1:0]               RRESP,
    input  logic                     RLAST,
    input  logic                     RVALID,
    output logic                     RREADY
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    arb_state_t               state, state_n;
    logic [7:0]               beat_cnt, beat_cnt_n;
    logic                     rresp_bad, rresp_bad_n;
    logic                     aw_done, aw_done_n;
    logic                     w_done, w_done_n;
    logic [VIDEOMEM_SIZE-1:0] ar_addr_q, ar_addr_n;
    logic [VIDEOMEM_SIZE-1:0] aw_addr_q, aw_addr_n;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_n;
    logic                     rd_ack_n, rd_done_n, rd_err_n;
    logic                     wr_ack_n, wr_done_n, wr_err_n;
    logic                     gnt_rd, gnt_wr;
    logic                     beat_bad;

    arb2_rr u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_rd (rd_req),
        .req_wr (wr_req),
        .urgent (rd_urgent),
        .update (state == ST_IDLE),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    assign ARADDR   = ar_addr_q;
    assign ARLEN    = LAST_BEAT;
    assign ARVALID  = (state == ST_RD_ADDR);
    assign RREADY   = (state == ST_RD_DATA);
    assign rd_valid = RVALID && RREADY;
    assign rd_data  = RDATA;
    assign AWADDR   = aw_addr_q;
    assign WDATA    = wdata_q;
    assign AWVALID  = (state == ST_WR_ADDR_DATA) && !aw_done;
    assign WVALID   = (state == ST_WR_ADDR_DATA) && !w_done;
    assign WLAST    = WVALID;
    assign BREADY   = (state == ST_WR_RESP);
    assign beat_bad = (RRESP != AXI_RESP_OKAY);

    always_comb begin
        state_n     = state;
        beat_cnt_n  = beat_cnt;
        rresp_bad_n = rresp_bad;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        ar_addr_n   = ar_addr_q;
        aw_addr_n   = aw_addr_q;
        wdata_n     = wdata_q;
        rd_ack_n    = 1'b0;
        rd_done_n   = 1'b0;
        rd_err_n    = 1'b0;
        wr_ack_n    = 1'b0;
        wr_done_n   = 1'b0;
        wr_err_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_rd) begin
                    state_n   = ST_RD_ADDR;
                    rd_ack_n  = 1'b1;
                    ar_addr_n = rd_addr;
                end else if (gnt_wr) begin
                    state_n   = ST_WR_ADDR_DATA;
                    wr_ack_n  = 1'b1;
                    aw_addr_n = wr_addr;
                    wdata_n   = wr_data;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                if (ARREADY) begin
                    state_n     = ST_RD_DATA;
                    beat_cnt_n  = 8'd0;
                    rresp_bad_n = 1'b0;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    // Burst ends on RLAST or on the nominal last beat, whichever comes first.
                    if (RLAST || (beat_cnt == LAST_BEAT)) begin
                        state_n   = ST_IDLE;
                        rd_done_n = 1'b1;
                        rd_err_n  = rresp_bad || beat_bad || !RLAST || (beat_cnt != LAST_BEAT);
                    end else begin
                        beat_cnt_n  = beat_cnt + 8'd1;
                        rresp_bad_n = rresp_bad || beat_bad;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                aw_done_n = aw_done || AWREADY;
                w_done_n  = w_done || WREADY;
                if (aw_done_n && w_done_n) begin
                    state_n   = ST_WR_RESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    state_n   = ST_IDLE;
                    wr_done_n = 1'b1;
                    wr_err_n  = (BRESP != AXI_RESP_OKAY);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= 8'd0;
            rresp_bad <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_addr_q <= '0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            rd_ack    <= 1'b0;
            rd_done   <= 1'b0;
            rd_err    <= 1'b0;
            wr_ack    <= 1'b0;
            wr_done   <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_n;
            beat_cnt  <= beat_cnt_n;
            rresp_bad <= rresp_bad_n;
            aw_done   <= aw_done_n;
            w_done    <= w_done_n;
            ar_addr_q <= ar_addr_n;
            aw_addr_q <= aw_addr_n;
            wdata_q   <= wdata_n;
            rd_ack    <= rd_ack_n;
            rd_done   <= rd_done_n;
            rd_err    <= rd_err_n;
            wr_ack    <= wr_ack_n;
            wr_done   <= wr_done_n;
            wr_err    <= wr_err_n;
        end
    end

endmodule
